// File: rtl/pkt_noc_arbiter.sv
// Packet-level round-robin arbiter feeding a single Avalon-ST NoC ingress port.
// Whole packets are granted at sop and held until eop; each packet carries the
// {dst, vc} routing tag of its requester, taken from the route table at grant.
module pkt_noc_arbiter #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_IN     = 4,
    parameter int NUM_VC     = 2,
    parameter int NOC_RADIX  = 16,
    localparam int EMPTY_W   = $clog2(DATA_WIDTH / 8),
    localparam int IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int DST_W     = (NOC_RADIX > 1) ? $clog2(NOC_RADIX) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_sop,
    input  logic [NUM_IN-1:0]            in_eop,
    input  logic [NUM_IN*EMPTY_W-1:0]    in_empty,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic [EMPTY_W-1:0]           out_empty,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [VC_W-1:0]              o_vc_id,
    output logic [DST_W-1:0]             o_noc_dst,
    input  logic                         cfg_we,
    input  logic [IDX_W-1:0]             cfg_idx,
    input  logic [DST_W-1:0]             cfg_dst,
    input  logic [VC_W-1:0]              cfg_vc,
    output logic [31:0]                  o_pkt_cnt,
    output logic [31:0]                  o_drop_cnt
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [DST_W-1:0]     cur_dst_q, cur_dst_d;
    logic [VC_W-1:0]      cur_vc_q, cur_vc_d;
    logic [DST_W-1:0]     rt_dst_q [NUM_IN];
    logic [VC_W-1:0]      rt_vc_q  [NUM_IN];

    logic                 out_valid_q, out_sop_q, out_eop_q;
    logic [EMPTY_W-1:0]   out_empty_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DST_W-1:0]     out_dst_q;
    logic [VC_W-1:0]      out_vc_q;
    logic [31:0]          pkt_cnt_q, drop_cnt_q;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W:0]       rot_sum;
    logic                 out_free;
    logic                 accept;
    logic [NUM_IN-1:0]    drop_mask;

    // Round-robin search: first requester at or after rr_ptr presenting a sop beat.
    // NOTE: combinational blocks use blocking '=' and give every target a default
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        rot_sum   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            rot_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (rot_sum >= (IDX_W + 1)'(NUM_IN)) begin
                rot_sum = rot_sum - (IDX_W + 1)'(NUM_IN);
            end
            cand = rot_sum[IDX_W-1:0];
            if (!win_found && in_valid[cand] && in_sop[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // FSM next state, per-requester ready, beat acceptance and orphan drops.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cur_dst_d = cur_dst_q;
        cur_vc_d  = cur_vc_q;
        in_ready  = '0;
        accept    = 1'b0;
        drop_mask = '0;
        out_free  = !out_valid_q || out_ready;
        case (state_q)
            IDLE: begin
                // Mid-packet beats with no owner are swallowed; the winner
                // itself sees no ready until the grant is registered.
                drop_mask = in_valid & ~in_sop;
                in_ready  = drop_mask;
                if (win_found) begin
                    grant_d   = win_idx;
                    cur_dst_d = rt_dst_q[win_idx];
                    cur_vc_d  = rt_vc_q[win_idx];
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                in_ready[grant_q] = out_free;
                accept            = in_valid[grant_q] && out_free;
                if (accept && in_eop[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ready must drop the moment reset is asserted, not at the next edge.
        if (!reset_n) begin
            in_ready  = '0;
            drop_mask = '0;
        end
    end

    // Control state, route table, output qualifiers and counters.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // values present before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cur_dst_q   <= '0;
            cur_vc_q    <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                rt_dst_q[i] <= DST_W'(i % NOC_RADIX);
                rt_vc_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            cur_dst_q <= cur_dst_d;
            cur_vc_q  <= cur_vc_d;
            if (cfg_we && (int'(cfg_idx) < NUM_IN)) begin
                rt_dst_q[cfg_idx] <= cfg_dst;
                rt_vc_q[cfg_idx]  <= cfg_vc;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                out_sop_q   <= in_sop[grant_q];
                out_eop_q   <= in_eop[grant_q];
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && in_eop[grant_q]) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            drop_cnt_q <= drop_cnt_q + 32'($countones(drop_mask));
        end
    end

    // Output payload and its routing tag travel together so a stalled last
    // beat keeps its own route while the next packet is already being granted.
    // NOTE: payload registers have no reset; out_valid qualifies them, so a
    // reset value would never be observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            out_data_q  <= in_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            out_empty_q <= in_empty[int'(grant_q) * EMPTY_W +: EMPTY_W];
            out_dst_q   <= cur_dst_q;
            out_vc_q    <= cur_vc_q;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_empty  = out_empty_q;
    assign out_data   = out_data_q;
    assign o_noc_dst  = out_dst_q;
    assign o_vc_id    = out_vc_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pkt_noc_arbiter.sv
// Self-checking bench for pkt_noc_arbiter: directed scenarios followed by
// randomized traffic, scored against a packet-level round-robin model.
`timescale 1ns/1ps
module tb_pkt_noc_arbiter;

    localparam int DW = 512;
    localparam int NI = 4;
    localparam int NV = 2;
    localparam int NR = 16;
    localparam int EW = $clog2(DW / 8);
    localparam int IW = $clog2(NI);
    localparam int VW = $clog2(NV);
    localparam int RW = $clog2(NR);

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NI-1:0]     in_valid = '0, in_sop = '0, in_eop = '0;
    logic [NI*EW-1:0]  in_empty = '0;
    logic [NI*DW-1:0]  in_data = '0;
    logic [NI-1:0]     in_ready;
    logic              out_valid, out_sop, out_eop;
    logic [EW-1:0]     out_empty;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic [VW-1:0]     o_vc_id;
    logic [RW-1:0]     o_noc_dst;
    logic              cfg_we = 1'b0;
    logic [IW-1:0]     cfg_idx = '0;
    logic [RW-1:0]     cfg_dst = '0;
    logic [VW-1:0]     cfg_vc = '0;
    logic [31:0]       o_pkt_cnt, o_drop_cnt;

    always #5 clk = ~clk;

    pkt_noc_arbiter #(.DATA_WIDTH(DW), .NUM_IN(NI), .NUM_VC(NV), .NOC_RADIX(NR)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
        .o_vc_id(o_vc_id), .o_noc_dst(o_noc_dst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dst(cfg_dst), .cfg_vc(cfg_vc),
        .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        beat_t         b;
        logic [RW-1:0] dst;
        logic [VW-1:0] vc;
    } obeat_t;

    beat_t  src_q [NI][$];   // per-requester beats still to be offered
    obeat_t exp_q [$];       // expected output beats in order
    int     m_dst [NI];
    int     m_vc  [NI];
    int     m_ptr, m_pkts, m_drops;
    int     n_checks = 0, n_pass = 0, n_fail = 0;
    int     first_out_cyc, last_out_cyc;
    logic [NI-1:0] ready_at_cyc0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_pkts = 0; m_drops = 0;
        for (int i = 0; i < NI; i++) begin
            m_dst[i] = i % NR;
            m_vc[i]  = 0;
            src_q[i].delete();
        end
        exp_q.delete();
    endtask

    task automatic add_pkt(input int req, input int nbeats, input bit mid_sop);
        for (int k = 0; k < nbeats; k++) begin
            beat_t b;
            b.data  = rand_data();
            b.empty = (k == nbeats - 1) ? EW'($urandom) : '0;
            b.sop   = (k == 0) || (mid_sop && ($urandom_range(0, 3) == 0));
            b.eop   = (k == nbeats - 1);
            src_q[req].push_back(b);
        end
    endtask

    // Packet-level schedule: every requester with queued packets competes;
    // each packet goes to the first such requester at or after the pointer.
    task automatic model_schedule();
        int rd [NI];
        int w;
        bit fin;
        beat_t b;
        for (int i = 0; i < NI; i++) rd[i] = 0;
        while (1) begin
            w = -1;
            for (int k = 0; k < NI; k++) begin
                int c = (m_ptr + k) % NI;
                if (w < 0 && rd[c] < src_q[c].size()) w = c;
            end
            if (w < 0) break;
            fin = 1'b0;
            while (!fin) begin
                b = src_q[w][rd[w]];
                rd[w]++;
                exp_q.push_back({b, RW'(m_dst[w]), VW'(m_vc[w])});
                fin = b.eop;
            end
            m_ptr = (w + 1) % NI;
            m_pkts++;
        end
    endtask

    task automatic cfg_write(input int idx, input int dst, input int vc);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_dst = RW'(dst); cfg_vc = VW'(vc);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_dst[idx] = dst; m_vc[idx] = vc;
    endtask

    task automatic apply_reset();
        in_valid = '0; cfg_we = 1'b0;
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    // Drives all queued packets, scores every output beat and hold cycle.
    // ready_mode: 0 always ready, 1 toggle 1/0, 2 random. Optional route write
    // at cycle cfg_cyc is applied to the model only after the run.
    task automatic run_traffic(input int ready_mode, input bit gaps, input int cfg_cyc,
                               input int ci, input int cd, input int cv, input int max_cyc);
        obeat_t prev, e;
        bit held = 1'b0, done = 1'b0;
        logic [NI-1:0] acc;
        model_schedule();
        first_out_cyc = -1; last_out_cyc = -1;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (src_q[i].size() > 0 &&
                    !(gaps && !src_q[i][0].sop && $urandom_range(0, 3) == 0)) begin
                    in_valid[i]           = 1'b1;
                    in_sop[i]             = src_q[i][0].sop;
                    in_eop[i]             = src_q[i][0].eop;
                    in_empty[i*EW +: EW]  = src_q[i][0].empty;
                    in_data[i*DW +: DW]   = src_q[i][0].data;
                end else begin
                    in_valid[i] = 1'b0;
                    in_sop[i]   = 1'($urandom);
                    in_eop[i]   = 1'($urandom);
                end
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
            cfg_we = (cyc == cfg_cyc);
            cfg_idx = IW'(ci); cfg_dst = RW'(cd); cfg_vc = VW'(cv);
            @(negedge clk);
            if (cyc == 0) ready_at_cyc0 = in_ready;
            check("ready_onehot", DW'($countones(in_ready) <= 1), DW'(1));
            if (held) begin
                check("hold_data", out_data, prev.b.data);
                check("hold_ctrl", DW'({out_valid, out_sop, out_eop, out_empty, o_noc_dst, o_vc_id}),
                      DW'({1'b1, prev.b.sop, prev.b.eop, prev.b.empty, prev.dst, prev.vc}));
            end
            if (out_valid && out_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_beat", DW'(out_valid), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.b.data);
                    check("out_ctrl", DW'({out_sop, out_eop, out_empty, o_noc_dst, o_vc_id}),
                          DW'({e.b.sop, e.b.eop, e.b.empty, e.dst, e.vc}));
                end
            end
            held = out_valid && !out_ready;
            prev = {out_data, out_empty, out_sop, out_eop, o_noc_dst, o_vc_id};
            acc  = in_valid & in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) if (acc[i]) src_q[i].delete(0);
            done = (exp_q.size() == 0);
        end
        cfg_we = 1'b0; in_valid = '0;
        check("run_complete", DW'(exp_q.size()), DW'(0));
        check("pkt_cnt", DW'(o_pkt_cnt), DW'(m_pkts));
        if (cfg_cyc >= 0) begin
            m_dst[ci] = cd; m_vc[ci] = cv;
        end
        for (int i = 0; i < NI; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        // Reset state, with an orphan beat present to prove ready is held low.
        in_valid = 4'b0100; in_sop = '0;
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_pkt_cnt", DW'(o_pkt_cnt), DW'(0));
        check("rst_drop_cnt", DW'(o_drop_cnt), DW'(0));
        in_valid = '0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Orphan beat on requester 2 while idle is dropped.
        in_valid = 4'b0100; in_sop = '0; in_eop = '0;
        @(negedge clk);
        check("drop_ready", DW'(in_ready), DW'(4'b0100));
        @(posedge clk); #1;
        in_valid = '0; m_drops++;
        @(negedge clk);
        check("drop_cnt", DW'(o_drop_cnt), DW'(m_drops));
        check("drop_no_out", DW'(out_valid), DW'(0));
        @(negedge clk);
        check("drop_no_out2", DW'(out_valid), DW'(0));
        @(posedge clk); #1;

        // Single 3-beat packet on requester 0 with a free output.
        add_pkt(0, 3, 1'b0);
        run_traffic(0, 1'b0, -1, 0, 0, 0, 200);
        check("arb_cycle_ready", DW'(ready_at_cyc0), DW'(0));
        check("first_beat_cyc", DW'(first_out_cyc), DW'(2));
        check("last_beat_cyc", DW'(last_out_cyc), DW'(4));

        // Four requesters with back-to-back single-beat packets.
        apply_reset();
        add_pkt(0, 1, 1'b0); add_pkt(0, 1, 1'b0);
        add_pkt(1, 1, 1'b0); add_pkt(2, 1, 1'b0); add_pkt(3, 1, 1'b0);
        run_traffic(0, 1'b0, -1, 0, 0, 0, 200);

        // Back-pressure toggling through a 4-beat packet.
        add_pkt(2, 4, 1'b0);
        run_traffic(1, 1'b0, -1, 0, 0, 0, 200);

        // Reprogrammed route on requester 1.
        cfg_write(1, 9, 1);
        add_pkt(1, 3, 1'b0);
        run_traffic(0, 1'b0, -1, 0, 0, 0, 200);

        // Route rewrite mid-packet leaves the packet's tag alone; next packet uses it.
        add_pkt(1, 4, 1'b0);
        run_traffic(0, 1'b0, 2, 1, 5, 0, 200);
        add_pkt(1, 2, 1'b0);
        run_traffic(0, 1'b0, -1, 0, 0, 0, 200);

        // Reset pulsed during beat 2 of a packet on requester 1.
        out_ready = 1'b1;
        in_valid = 4'b0010; in_sop = 4'b0010; in_eop = '0;
        in_data[DW +: DW] = rand_data();
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_sop = '0; in_data[DW +: DW] = rand_data();
        @(negedge clk);
        check("mid_pkt_valid", DW'(out_valid), DW'(1));
        #2 reset_n = 1'b0;
        #1;
        check("async_out_valid", DW'(out_valid), DW'(0));
        check("async_in_ready", DW'(in_ready), DW'(0));
        check("async_pkt_cnt", DW'(o_pkt_cnt), DW'(0));
        in_valid = '0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        add_pkt(3, 3, 1'b0);
        run_traffic(0, 1'b0, -1, 0, 0, 0, 200);

        // Randomized traffic with random routes, gaps and back-pressure.
        apply_reset();
        for (int i = 0; i < NI; i++) cfg_write(i, $urandom_range(0, NR - 1), $urandom_range(0, NV - 1));
        for (int p = 0; p < 30; p++) add_pkt($urandom_range(0, NI - 1), $urandom_range(1, 5), 1'b1);
        run_traffic(2, 1'b1, -1, 0, 0, 0, 5000);
        for (int p = 0; p < 20; p++) add_pkt($urandom_range(0, NI - 1), $urandom_range(1, 4), 1'b1);
        run_traffic(1, 1'b1, -1, 0, 0, 0, 5000);
        @(negedge clk);
        check("final_drop_cnt", DW'(o_drop_cnt), DW'(m_drops));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_noc_arbiter.md
PKT_NOC_ARBITER -- requirements
Module: pkt_noc_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, Avalon-ST data width in bits, multiple of 64.
REQ-002 SHALL have parameter NUM_IN, default 4, number of packet requesters, range 2..8.
REQ-003 SHALL have parameter NUM_VC, default 2, number of NoC virtual channels.
REQ-004 SHALL have parameter NOC_RADIX, default 16, number of NoC destinations.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have in_valid/in_sop/in_eop, input, NUM_IN each, per-requester Avalon-ST qualifiers.
REQ-008 SHALL have in_empty, input, NUM_IN*log2(DATA_WIDTH/8), per-requester empty bytes.
REQ-009 SHALL have in_data, input, NUM_IN*DATA_WIDTH, per-requester data.
REQ-010 SHALL have in_ready, output, NUM_IN, per-requester ready.
REQ-011 SHALL have out_valid/out_sop/out_eop, output, 1 each; out_empty and out_data at single-requester width; out_ready, input, 1.
REQ-012 SHALL have o_vc_id, output, clog2(NUM_VC), and o_noc_dst, output, clog2(NOC_RADIX): routing tag of the current output beat.
REQ-013 SHALL have cfg_we, input, 1; cfg_idx, input, clog2(NUM_IN); cfg_dst, input, clog2(NOC_RADIX); cfg_vc, input, clog2(NUM_VC): per-requester route table write port.
REQ-014 SHALL have o_pkt_cnt, output, 32, count of packets forwarded; o_drop_cnt, output, 32, count of orphan beats discarded.

Function
REQ-015 SHALL hold a route table of NUM_IN entries {dst, vc}; cfg_we writes entry cfg_idx at the clock edge, taking effect for packets granted from the next cycle.
REQ-016 SHALL implement FSM states IDLE and BUSY.
REQ-017 In IDLE, eligible requesters SHALL be those with in_valid=1 and in_sop=1; the winner is the first eligible index at or after rr_ptr, modulo NUM_IN.
REQ-018 On a win, the arbiter SHALL register grant=winner, latch the winner's route entry, and enter BUSY next cycle; no in_ready is asserted in the arbitration cycle.
REQ-019 In IDLE, a requester with in_valid=1 and in_sop=0 SHALL receive in_ready=1, its beat is discarded, and o_drop_cnt increments by one per discarded beat.
REQ-020 In BUSY, in_ready[grant] SHALL equal (!out_valid || out_ready); all other in_ready are 0.
REQ-021 The output stage SHALL be a single register: an accepted beat appears on out_* the next cycle; latency 1 beat from acceptance.
REQ-022 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 o_vc_id/o_noc_dst SHALL be the latched route entry, constant for every beat of a packet, valid whenever out_valid=1.
REQ-024 Acceptance of a beat with in_eop=1 SHALL return the FSM to IDLE, set rr_ptr=(grant+1) mod NUM_IN, and increment o_pkt_cnt.
REQ-025 A beat with both sop and eop SHALL be a complete single-beat packet.
REQ-026 In BUSY, an in_sop=1 on the granted input before eop SHALL be forwarded unchanged, without restarting arbitration.
REQ-027 Counters SHALL wrap from 2^32-1 to 0.
REQ-028 cfg_we to the index of the active grant SHALL NOT change o_vc_id/o_noc_dst of the packet in flight.

Reset
REQ-029 reset_n=0 SHALL immediately force FSM=IDLE, rr_ptr=0, grant=0, out_valid=0, out_sop=0, out_eop=0, in_ready=0, and all counters to 0.
REQ-030 Route table SHALL reset to entry i = {dst=i mod NOC_RADIX, vc=0}.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from index 0.

Verification
REQ-032 Single requester 0, 3-beat packet, out_ready=1 -> grant after 1 idle cycle, 3 output beats with sop on beat 1 and eop on beat 3, o_pkt_cnt=1.
REQ-033 All 4 requesters hold 1-beat packets continuously -> grant order 0,1,2,3,0, each packet carrying its reset route (dst=index, vc=0).
REQ-034 out_ready toggling 1,0,1,0 during a 4-beat packet -> no beat lost or duplicated, and out_* stable in every out_ready=0 cycle.
REQ-035 Requester 2 presents valid, sop=0 while IDLE -> beat dropped, o_drop_cnt=1, no output beat.
REQ-036 cfg write {idx=1, dst=9, vc=1}, then packet on requester 1 -> o_noc_dst=9, o_vc_id=1 on all of its beats.
REQ-037 reset_n pulsed low during beat 2 of a packet -> out_valid=0 asynchronously; after release, a new packet from requester 3 is forwarded correctly.
